add_round_key_pipe: RTL and testbench

//   Registered, parametrised AddRoundKey / InvAddRoundKey stage for the AES datapath.

---
 rtl/add_round_key_pipe_if.sv | 26 ++
 rtl/add_round_key_pipe.sv | 81 ++++++++
 tb/tb_add_round_key_pipe.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_round_key_pipe_if.sv
// Valid/ready stream bundle for the AddRoundKey stage: state words in, keyed words out.
// The stage itself uses the slave view; the producer/consumer side uses the master view.
interface add_round_key_pipe_if #(
  parameter int DATA_W = 128,
  parameter int IDX_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_state;
  logic [IDX_W-1:0]  in_round;
  logic              in_decrypt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_state;
  logic              out_err;

  modport slave (
    input  in_valid, in_state, in_round, in_decrypt, out_ready,
    output in_ready, out_valid, out_state, out_err
  );

  modport master (
    output in_valid, in_state, in_round, in_decrypt, out_ready,
    input  in_ready, out_valid, out_state, out_err
  );
endinterface

// File: rtl/add_round_key_pipe.sv
// Registered AddRoundKey / InvAddRoundKey stage with a round-key bank and a one-deep
// valid/ready output register; bad or missing keys pass the word through and flag out_err.
module add_round_key_pipe #(
  parameter int DATA_W   = 128,
  parameter int NUM_KEYS = 15,
  parameter int IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_wr_en,
  input  logic [IDX_W-1:0]  key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              key_clr,
  input  logic [IDX_W-1:0]  cfg_last_idx,
  add_round_key_pipe_if.slave bus
);

  localparam logic [IDX_W:0] NUM_KEYS_W = NUM_KEYS[IDX_W:0];

  logic [DATA_W-1:0]   key_mem [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_valid;
  logic [NUM_KEYS-1:0] key_valid_nxt;

  logic              wr_ok;
  logic [IDX_W-1:0]  eff_idx;
  logic [IDX_W-1:0]  eff_safe;
  logic              range_err;
  logic              wt_hit;
  logic              sel_err;
  logic [DATA_W-1:0] sel_key;
  logic              accept;

  assign wr_ok = key_wr_en && ({1'b0, key_wr_idx} < NUM_KEYS_W);

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    key_valid_nxt = key_clr ? '0 : key_valid;
    if (wr_ok) key_valid_nxt[key_wr_idx] = 1'b1;
  end

  // NOTE: key storage has no reset; only the valid bits do, which keeps the bank a plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) key_mem[key_wr_idx] <= key_wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_valid <= '0;
    else     key_valid <= key_valid_nxt;
  end

  // Key selection sees this cycle's write/clear, giving write-through to an accepted word.
  assign eff_idx   = bus.in_decrypt ? (cfg_last_idx - bus.in_round) : bus.in_round;
  assign range_err = (bus.in_round > cfg_last_idx) || ({1'b0, cfg_last_idx} >= NUM_KEYS_W);
  assign eff_safe  = range_err ? '0 : eff_idx;
  assign wt_hit    = wr_ok && (key_wr_idx == eff_safe);
  assign sel_err   = range_err || !key_valid_nxt[eff_safe];

  always_comb begin
    sel_key = '0;
    if (!sel_err) sel_key = wt_hit ? key_wr_data : key_mem[eff_safe];
  end

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_state <= '0;
      bus.out_err   <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_state <= bus.in_state ^ sel_key;
      bus.out_err   <= sel_err;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_round_key_pipe.sv
// Self-checking bench for add_round_key_pipe: directed vector table, hand sequences for
// stall/reset/write-through, and a random phase scored against a key-table reference model.
module tb_add_round_key_pipe;

  localparam int DATA_W   = 128;
  localparam int NUM_KEYS = 15;
  localparam int IDX_W    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              key_wr_en = 1'b0;
  logic [IDX_W-1:0]  key_wr_idx = '0;
  logic [DATA_W-1:0] key_wr_data = '0;
  logic              key_clr = 1'b0;
  logic [IDX_W-1:0]  cfg_last_idx = 4'd10;

  add_round_key_pipe_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  add_round_key_pipe #(.DATA_W(DATA_W), .NUM_KEYS(NUM_KEYS), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_wr_en    (key_wr_en),
    .key_wr_idx   (key_wr_idx),
    .key_wr_data  (key_wr_data),
    .key_clr      (key_clr),
    .cfg_last_idx (cfg_last_idx),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a table of keys with presence flags, and a queue of expected outputs.
  typedef struct {
    logic [DATA_W-1:0] st;
    bit                er;
  } exp_t;

  logic [DATA_W-1:0] mdl_key [16];
  bit                mdl_vld [16];
  exp_t              q [$];

  function automatic exp_t predict(input logic [DATA_W-1:0] s, input int rnd, input bit dec);
    exp_t e;
    int   last = int'(cfg_last_idx);
    int   eff  = dec ? ((last - rnd) & 15) : rnd;
    if (rnd > last || last >= NUM_KEYS || !mdl_vld[eff]) begin
      e.st = s;
      e.er = 1'b1;
    end else begin
      e.st = s ^ mdl_key[eff];
      e.er = 1'b0;
    end
    return e;
  endfunction

  always @(posedge rst) begin
    q.delete();
    for (int i = 0; i < 16; i++) mdl_vld[i] = 1'b0;
  end

  // Cycle monitor: sampled mid-cycle, before the edge the observed inputs apply to.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
      check("out_valid_vs_model", bus.out_valid, q.size() != 0);
      if (bus.out_valid && q.size() != 0) begin
        check("sb_out_state", bus.out_state, q[0].st);
        check("sb_out_err", bus.out_err, q[0].er);
        if (bus.out_ready) void'(q.pop_front());
      end
      if (key_clr) for (int i = 0; i < 16; i++) mdl_vld[i] = 1'b0;
      if (key_wr_en && int'(key_wr_idx) < NUM_KEYS) begin
        mdl_key[key_wr_idx] = key_wr_data;
        mdl_vld[key_wr_idx] = 1'b1;
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(predict(bus.in_state, int'(bus.in_round), bus.in_decrypt));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input int idx, input logic [DATA_W-1:0] data);
    key_wr_en   = 1'b1;
    key_wr_idx  = IDX_W'(idx);
    key_wr_data = data;
    next_cycle();
    key_wr_en = 1'b0;
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send(input logic [DATA_W-1:0] s, input int rnd, input bit dec);
    bit acc = 1'b0;
    bus.in_state   = s;
    bus.in_round   = IDX_W'(rnd);
    bus.in_decrypt = dec;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      next_cycle();
    end
    bus.in_valid = 1'b0;
    if (!acc) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      next_cycle();
      done = (q.size() == 0) && !bus.out_valid;
    end
    check("drain_done", done, 1'b1);
  endtask

  typedef struct {
    logic [DATA_W-1:0] state;
    int                round;
    bit                dec;
    logic [DATA_W-1:0] exp_state;
    bit                exp_err;
  } vec_t;

  localparam logic [DATA_W-1:0] K0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [DATA_W-1:0] K10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [DATA_W-1:0] K3  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
  localparam logic [DATA_W-1:0] K3B = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  vec_t vecs [6];

  initial begin
    logic [DATA_W-1:0] s;

    vecs[0] = '{128'h3243f6a8_885a308d_313198a2_e0370734, 0, 1'b0,
                128'h193de3be_a0f4e22b_9ac68d2a_e9f84808, 1'b0};
    vecs[1] = '{128'h11112222_33334444_55556666_77778888, 0, 1'b1,
                128'h11112222_33334444_55556666_77778888 ^ K10, 1'b0};
    vecs[2] = '{128'hcafef00d_deadbeef_01020304_05060708, 10, 1'b1,
                128'hcafef00d_deadbeef_01020304_05060708 ^ K0, 1'b0};
    vecs[3] = '{128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0, 5, 1'b0,
                128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0, 1'b1};
    vecs[4] = '{128'h00112233_44556677_8899aabb_ccddeeff, 11, 1'b0,
                128'h00112233_44556677_8899aabb_ccddeeff, 1'b1};
    vecs[5] = '{128'hffeeddcc_bbaa9988_77665544_33221100, 10, 1'b0,
                128'hffeeddcc_bbaa9988_77665544_33221100 ^ K10, 1'b0};

    bus.in_valid = 1'b0; bus.in_state = '0; bus.in_round = '0;
    bus.in_decrypt = 1'b0; bus.out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_state", bus.out_state, '0);
    check("rst_out_err", bus.out_err, 1'b0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    next_cycle();
    check("post_rst_in_ready", bus.in_ready, 1'b1);

    // Directed table: FIPS-197 round 0, decrypt ordering, error words, recovery
    write_key(0, K0);
    write_key(10, K10);
    write_key(15, {DATA_W{1'b1}});   // out-of-range slot, must be ignored
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].state, vecs[i].round, vecs[i].dec);
      check($sformatf("vec%0d_state", i), bus.out_state, vecs[i].exp_state);
      check($sformatf("vec%0d_err", i), bus.out_err, vecs[i].exp_err);
    end
    drain();

    // Last index beyond the key bank: every read is a range error
    cfg_last_idx = 4'd15;
    send(128'h1234, 2, 1'b0);
    check("cfg_range_err", bus.out_err, 1'b1);
    check("cfg_range_state", bus.out_state, 128'h1234);
    drain();
    cfg_last_idx = 4'd10;

    // Back-pressure: four back-to-back words, out_ready low for cycles 2-4
    bus.out_ready = 1'b1;
    fork
      begin
        for (int w = 0; w < 4; w++)
          send(128'h1000 + 128'(w), (w == 2) ? 10 : 0, w[0]);
      end
      begin
        next_cycle();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall_in_ready", bus.in_ready, 1'b0);
          next_cycle();
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Write-through into the accepted word's slot, then clear, then clear+write together
    key_wr_en = 1'b1; key_wr_idx = 4'd3; key_wr_data = K3;
    send(128'h5555, 3, 1'b0);
    key_wr_en = 1'b0;
    check("wt_state", bus.out_state, 128'h5555 ^ K3);
    check("wt_err", bus.out_err, 1'b0);
    key_clr = 1'b1;
    next_cycle();
    key_clr = 1'b0;
    send(128'h6666, 3, 1'b0);
    check("clr_err", bus.out_err, 1'b1);
    check("clr_state", bus.out_state, 128'h6666);
    key_clr = 1'b1; key_wr_en = 1'b1; key_wr_idx = 4'd3; key_wr_data = K3B;
    send(128'h7777, 3, 1'b0);
    key_clr = 1'b0; key_wr_en = 1'b0;
    check("clr_wr_state", bus.out_state, 128'h7777 ^ K3B);
    check("clr_wr_err", bus.out_err, 1'b0);
    drain();

    // Async reset in the middle of a stall
    bus.out_ready = 1'b0;
    send(128'h8888, 3, 1'b0);
    next_cycle();
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_out_state", bus.out_state, '0);
    check("midrst_out_err", bus.out_err, 1'b0);
    next_cycle();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    next_cycle();
    for (int r = 0; r <= 10; r += 5) begin
      send(128'h9999, r, 1'b0);
      check($sformatf("after_rst_err_r%0d", r), bus.out_err, 1'b1);
    end
    write_key(5, K3);
    send(128'h9999, 5, 1'b0);
    check("reload_err", bus.out_err, 1'b0);
    check("reload_state", bus.out_state, 128'h9999 ^ K3);
    drain();

    // Random phase against the reference model
    for (int phase = 0; phase < 2; phase++) begin
      cfg_last_idx = (phase == 0) ? 4'd14 : 4'd10;
      for (int i = 0; i < NUM_KEYS; i++)
        if ($urandom_range(0, 4) != 0) write_key(i, {$urandom, $urandom, $urandom, $urandom});
      for (int c = 0; c < 400; c++) begin
        bus.out_ready  = ($urandom_range(0, 3) != 0);
        bus.in_valid   = ($urandom_range(0, 2) != 0);
        s              = {$urandom, $urandom, $urandom, $urandom};
        bus.in_state   = s;
        bus.in_round   = IDX_W'($urandom_range(0, 15));
        bus.in_decrypt = $urandom_range(0, 1);
        key_wr_en      = ($urandom_range(0, 5) == 0);
        key_wr_idx     = IDX_W'($urandom_range(0, 15));
        key_wr_data    = {$urandom, $urandom, $urandom, $urandom};
        key_clr        = !bus.in_valid && ($urandom_range(0, 60) == 0);
        next_cycle();
      end
      key_wr_en = 1'b0;
      key_clr   = 1'b0;
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
